// File: rtl/stack_sequencer.sv
// rtl/stack_sequencer.sv - EX/MEM sequencer running CALL/RET/INT/RTI as 16-bit stack accesses
// Optional STACK_BOUND_CHECK_EN rejects ops that would push below SP_LIMIT or pop above SP_RESET.
module stack_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] pc_in,
  input  logic [31:0] target_in,
  input  logic [2:0]  flags_in,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [31:0] sp,
  output logic        pc_load,
  output logic [31:0] pc_out,
  output logic        flags_load,
  output logic [2:0]  flags_out,
  output logic        done,
  output logic        stack_fault
);
  localparam logic [31:0] SP_RESET   = 32'h000F_FFFF;
  localparam logic [31:0] INT_VECTOR = 32'h0000_0000;
  localparam logic [1:0]  OP_CALL = 2'b00;
  localparam logic [1:0]  OP_INT  = 2'b10;
  localparam logic [1:0]  OP_RTI  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_FIN} state_t;

  state_t      state_q;
  logic [1:0]  op_q, k_q, n_q;
  logic [15:0] pc_lo_q, lo_q;
  logic [31:0] target_q, sp_q, mem_addr_q, pc_out_q;
  logic [2:0]  push_flags_q, rflags_q, flags_out_q;
  logic [15:0] mem_wdata_q;
  logic        mem_req_q, mem_we_q, pc_load_q, flags_load_q, done_q;
  logic [1:0]  start_n;
  logic        push_q, fault;

  // op[0]==0 selects a push (CALL/INT); op[1] selects the 3-word forms (INT/RTI)
  assign start_n = op[1] ? 2'd3 : 2'd2;
  assign push_q  = ~op_q[0];

`ifdef STACK_BOUND_CHECK_EN
  localparam logic [31:0] SP_LIMIT = 32'h000F_F000;
  logic [32:0] low_addr, high_addr;
  assign low_addr  = {1'b0, sp_q} - {31'b0, start_n} + 33'd1;
  assign high_addr = {1'b0, sp_q} + {31'b0, start_n};
  assign fault = start && (state_q == S_IDLE) &&
                 (~op[0] ? (low_addr[32] || (low_addr[31:0] < SP_LIMIT))
                         : (high_addr > {1'b0, SP_RESET}));
`else
  assign fault = 1'b0;
`endif

  assign stall       = start || (state_q != S_IDLE);
  assign stack_fault = fault;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign sp          = sp_q;
  assign pc_load     = pc_load_q;
  assign pc_out      = pc_out_q;
  assign flags_load  = flags_load_q;
  assign flags_out   = flags_out_q;
  assign done        = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= 2'b00;
      k_q          <= 2'd0;
      n_q          <= 2'd0;
      pc_lo_q      <= 16'h0;
      lo_q         <= 16'h0;
      target_q     <= 32'h0;
      push_flags_q <= 3'b0;
      rflags_q     <= 3'b0;
      sp_q         <= SP_RESET;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 16'h0;
      pc_load_q    <= 1'b0;
      pc_out_q     <= 32'h0;
      flags_load_q <= 1'b0;
      flags_out_q  <= 3'b0;
      done_q       <= 1'b0;
    end else begin
      pc_load_q    <= 1'b0;
      flags_load_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !fault) begin
            state_q      <= S_XFER;
            op_q         <= op;
            pc_lo_q      <= pc_in[15:0];
            target_q     <= target_in;
            push_flags_q <= flags_in;
            k_q          <= 2'd0;
            n_q          <= start_n;
            mem_req_q    <= 1'b1;
            mem_we_q     <= ~op[0];
            mem_addr_q   <= op[0] ? sp_q + 32'd1 : sp_q;
            mem_wdata_q  <= op[0] ? 16'h0 : pc_in[31:16];
          end
        end
        S_XFER: begin
          if (mem_ready) begin
            sp_q <= push_q ? sp_q - 32'd1 : sp_q + 32'd1;
            if (op_q == OP_RTI && k_q == 2'd0) rflags_q <= mem_rdata[2:0];
            else if (!push_q) lo_q <= mem_rdata;
            if (k_q == n_q - 2'd1) begin
              state_q     <= S_FIN;
              mem_req_q   <= 1'b0;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= 32'h0;
              mem_wdata_q <= 16'h0;
              pc_load_q   <= 1'b1;
              done_q      <= 1'b1;
              if (op_q == OP_CALL)     pc_out_q <= target_q;
              else if (op_q == OP_INT) pc_out_q <= INT_VECTOR;
              else                     pc_out_q <= {mem_rdata, lo_q};
              if (op_q == OP_RTI) begin
                flags_load_q <= 1'b1;
                flags_out_q  <= rflags_q;
              end
            end else begin
              k_q         <= k_q + 2'd1;
              mem_addr_q  <= push_q ? sp_q - 32'd1 : sp_q + 32'd2;
              mem_wdata_q <= !push_q ? 16'h0 :
                             (k_q == 2'd0) ? pc_lo_q : {13'b0, push_flags_q};
            end
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stack_sequencer.sv
// tb/tb_stack_sequencer.sv - randomized self-checking bench for stack_sequencer against a word-stack model
module tb_stack_sequencer;
  localparam logic [31:0] SP_RESET   = 32'h000F_FFFF;
  localparam logic [31:0] INT_VECTOR = 32'h0000_0000;
  localparam logic [1:0] OP_CALL = 2'b00, OP_RET = 2'b01, OP_INT = 2'b10, OP_RTI = 2'b11;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, mem_ready = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] pc_in = 32'h0, target_in = 32'h0;
  logic [2:0]  flags_in = 3'b0;
  logic [15:0] mem_rdata = 16'h0;
  logic        stall, mem_req, mem_we, pc_load, flags_load, done, stack_fault;
  logic [31:0] mem_addr, sp, pc_out;
  logic [15:0] mem_wdata;
  logic [2:0]  flags_out;

  int n_vec = 0, n_err = 0;
  logic [31:0] sp_m;
  logic [15:0] stk[$];
  logic [15:0] bmem [0:4095];

  stack_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .pc_in(pc_in), .target_in(target_in),
    .flags_in(flags_in), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .sp(sp),
    .pc_load(pc_load), .pc_out(pc_out), .flags_load(flags_load), .flags_out(flags_out),
    .done(done), .stack_fault(stack_fault)
  );

  always #5 clk = ~clk;

  // Caller sits at a negedge; returns at the negedge of the cycle after FIN so ops can run back to back.
  task automatic do_op(input logic [1:0] o, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic [2:0] fl, input int w0, input int w1, input int w2);
    logic [15:0] wd [3];
    logic [31:0] ad [3];
    int waits [3];
    int n, k, cyc, wleft, fin_cyc;
    bit push, seen;
    logic [31:0] sp0, exp_pc, exp_sp;
    logic [2:0] exp_fl;
    n = o[1] ? 3 : 2;
    push = (o == OP_CALL) || (o == OP_INT);
    waits[0] = w0; waits[1] = w1; waits[2] = w2;
    sp0 = sp_m;
    exp_fl = 3'b0;
    if (push) begin
      wd[0] = pc[31:16]; wd[1] = pc[15:0]; wd[2] = {13'b0, fl};
      for (int i = 0; i < n; i++) begin
        ad[i] = sp0 - 32'(i);
        stk.push_back(wd[i]);
      end
      exp_pc = (o == OP_CALL) ? tgt : INT_VECTOR;
      exp_sp = sp0 - 32'(n);
    end else begin
      for (int i = 0; i < n; i++) begin
        ad[i] = sp0 + 32'(i + 1);
        wd[i] = stk.pop_back();
      end
      exp_sp = sp0 + 32'(n);
      if (o == OP_RET) exp_pc = {wd[1], wd[0]};
      else begin
        exp_fl = wd[0][2:0];
        exp_pc = {wd[2], wd[1]};
      end
    end
    fin_cyc = n + w0 + w1 + ((n == 3) ? w2 : 0) + 1;

    start = 1'b1; op = o; pc_in = pc; target_in = tgt; flags_in = fl; mem_ready = 1'b0;
    #1;
    n_vec++;
    if (stall !== 1'b1 || stack_fault !== 1'b0 || mem_req !== 1'b0) begin
      n_err++; $display("FAIL start_cycle stall=%b fault=%b req=%b want 1 0 0", stall, stack_fault, mem_req);
    end
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); pc_in = $urandom; target_in = $urandom; flags_in = 3'($urandom);
    k = 0; wleft = waits[0]; seen = 1'b0; cyc = 1;
    while (!seen && cyc < 40) begin
      if (pc_load === 1'b1) begin
        seen = 1'b1;
        n_vec++;
        if (cyc != fin_cyc) begin n_err++; $display("FAIL fin_cycle got %0d want %0d", cyc, fin_cyc); end
        n_vec++;
        if (pc_out !== exp_pc) begin n_err++; $display("FAIL pc_out got %h want %h", pc_out, exp_pc); end
        n_vec++;
        if (done !== 1'b1 || stall !== 1'b1 || flags_load !== (o == OP_RTI)) begin
          n_err++; $display("FAIL fin_ctrl done=%b stall=%b flags_load=%b want 1 1 %b", done, stall, flags_load, o == OP_RTI);
        end
        if (o == OP_RTI) begin
          n_vec++;
          if (flags_out !== exp_fl) begin n_err++; $display("FAIL flags_out got %b want %b", flags_out, exp_fl); end
        end
        n_vec++;
        if (sp !== exp_sp) begin n_err++; $display("FAIL sp_fin got %h want %h", sp, exp_sp); end
        n_vec++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 16'h0) begin
          n_err++; $display("FAIL fin_bus req=%b addr=%h wdata=%h want 0 0 0", mem_req, mem_addr, mem_wdata);
        end
        mem_ready = 1'b0;
      end else if (k >= n) begin
        seen = 1'b1;
        n_vec++; n_err++; $display("FAIL fin_missing pc_load=%b want 1 at cycle %0d", pc_load, cyc);
      end else begin
        n_vec++;
        if (stall !== 1'b1 || mem_req !== 1'b1 || mem_we !== push) begin
          n_err++; $display("FAIL xfer_ctrl stall=%b req=%b we=%b want 1 1 %b", stall, mem_req, mem_we, push);
        end
        n_vec++;
        if (mem_addr !== ad[k]) begin n_err++; $display("FAIL addr word %0d got %h want %h", k, mem_addr, ad[k]); end
        if (push) begin
          n_vec++;
          if (mem_wdata !== wd[k]) begin n_err++; $display("FAIL wdata word %0d got %h want %h", k, mem_wdata, wd[k]); end
        end
        n_vec++;
        if (sp !== (push ? sp0 - 32'(k) : sp0 + 32'(k))) begin
          n_err++; $display("FAIL sp_xfer word %0d got %h want %h", k, sp, push ? sp0 - 32'(k) : sp0 + 32'(k));
        end
        mem_ready = (wleft == 0);
        mem_rdata = push ? 16'($urandom) : bmem[mem_addr[11:0]];
        if (wleft == 0) begin
          if (push) bmem[mem_addr[11:0]] = mem_wdata;
          k++;
          if (k < n) wleft = waits[k];
        end else wleft--;
      end
      @(negedge clk);
      cyc++;
    end
    if (!seen) begin n_vec++; n_err++; $display("FAIL timeout op=%0d no pc_load within 40 cycles", o); end
    sp_m = exp_sp;
    n_vec++;
    if (pc_load !== 1'b0 || done !== 1'b0 || flags_load !== 1'b0 || stall !== 1'b0 || mem_req !== 1'b0) begin
      n_err++; $display("FAIL post_fin load=%b done=%b fl=%b stall=%b req=%b want all 0", pc_load, done, flags_load, stall, mem_req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (sp !== SP_RESET || pc_out !== 32'h0 || flags_out !== 3'b0 || mem_addr !== 32'h0 || mem_wdata !== 16'h0) begin
      n_err++; $display("FAIL reset_words sp=%h pc=%h fl=%b addr=%h wd=%h want %h 0 0 0 0", sp, pc_out, flags_out, mem_addr, mem_wdata, SP_RESET);
    end
    n_vec++;
    if ({stall, mem_req, mem_we, pc_load, flags_load, done, stack_fault} !== 7'b0) begin
      n_err++; $display("FAIL reset_bits got %b want 0000000", {stall, mem_req, mem_we, pc_load, flags_load, done, stack_fault});
    end
    rst = 1'b0;
    sp_m = SP_RESET;
    stk.delete();
    @(negedge clk);
  endtask

  task automatic test_call_ret();
    do_op(OP_CALL, 32'h0001_0024, 32'h0000_0100, 3'b0, 0, 0, 0);
    n_vec++;
    if (bmem[12'hFFF] !== 16'h0001 || bmem[12'hFFE] !== 16'h0024 || sp !== 32'h000F_FFFD) begin
      n_err++; $display("FAIL call_mem hi=%h lo=%h sp=%h want 0001 0024 000ffffd", bmem[12'hFFF], bmem[12'hFFE], sp);
    end
    do_op(OP_RET, $urandom, $urandom, 3'($urandom), 0, 0, 0);
    n_vec++;
    if (sp !== 32'h000F_FFFF) begin n_err++; $display("FAIL ret_sp got %h want 000fffff", sp); end
  endtask

  task automatic test_int_rti();
    do_op(OP_INT, 32'hCAFE_1234, $urandom, 3'b101, 0, 0, 0);
    n_vec++;
    if (bmem[12'hFFD] !== 16'h0005 || sp !== 32'h000F_FFFC) begin
      n_err++; $display("FAIL int_mem flags_word=%h sp=%h want 0005 000ffffc", bmem[12'hFFD], sp);
    end
    do_op(OP_RTI, $urandom, $urandom, 3'($urandom), 0, 0, 0);
    n_vec++;
    if (pc_out !== 32'hCAFE_1234 || flags_out !== 3'b101 || sp !== 32'h000F_FFFF) begin
      n_err++; $display("FAIL rti_restore pc=%h fl=%b sp=%h want cafe1234 101 000fffff", pc_out, flags_out, sp);
    end
  endtask

  task automatic test_wait_states();
    do_op(OP_CALL, $urandom, $urandom, 3'b0, 0, 3, 0);
    do_op(OP_RET, $urandom, $urandom, 3'b0, 2, 1, 0);
  endtask

  task automatic test_reset_mid();
    start = 1'b1; op = OP_INT; pc_in = $urandom; flags_in = 3'b011; mem_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (mem_req !== 1'b1) begin n_err++; $display("FAIL mid_req got %b want 1", mem_req); end
    mem_ready = 1'b1;
    bmem[mem_addr[11:0]] = mem_wdata;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0;
    n_vec++;
    if (sp !== SP_RESET || {stall, mem_req, mem_we, pc_load, flags_load, done} !== 6'b0 || mem_addr !== 32'h0 || mem_wdata !== 16'h0) begin
      n_err++; $display("FAIL mid_reset sp=%h bits=%b addr=%h wd=%h want %h 000000 0 0", sp,
                        {stall, mem_req, mem_we, pc_load, flags_load, done}, mem_addr, mem_wdata, SP_RESET);
    end
    sp_m = SP_RESET;
    stk.delete();
    @(negedge clk);
    n_vec++;
    if (pc_load !== 1'b0 || mem_req !== 1'b0) begin n_err++; $display("FAIL mid_no_load load=%b req=%b want 0 0", pc_load, mem_req); end
    do_op(OP_CALL, $urandom, $urandom, 3'b0, 0, 0, 0);
    do_op(OP_RET, $urandom, $urandom, 3'b0, 0, 0, 0);
  endtask

  task automatic test_random_back_to_back();
    for (int i = 0; i < 40; i++) begin
      logic [1:0] o;
      o = 2'($urandom_range(0, 3));
      if (o[0] && stk.size() < (o[1] ? 3 : 2)) o[0] = 1'b0;
      if (!o[0] && stk.size() > 200) o[0] = 1'b1;
      if (o[0] && stk.size() < (o[1] ? 3 : 2)) o = OP_RET;
      do_op(o, $urandom, $urandom, 3'($urandom),
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end
  endtask

`ifdef STACK_BOUND_CHECK_EN
  task automatic test_bound_fault();
    test_reset();
    start = 1'b1; op = OP_RET;
    #1;
    n_vec++;
    if (stack_fault !== 1'b1 || stall !== 1'b1) begin
      n_err++; $display("FAIL fault_pulse fault=%b stall=%b want 1 1", stack_fault, stall);
    end
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (mem_req !== 1'b0 || sp !== SP_RESET || pc_load !== 1'b0 || done !== 1'b0 || stack_fault !== 1'b0 || stall !== 1'b0) begin
      n_err++; $display("FAIL fault_after req=%b sp=%h load=%b done=%b fault=%b stall=%b want 0 %h 0 0 0 0",
                        mem_req, sp, pc_load, done, stack_fault, stall, SP_RESET);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4096; i++) bmem[i] = 16'h0;
    sp_m = SP_RESET;
    test_reset();
    test_call_ret();
    test_int_rti();
    test_wait_states();
    test_reset_mid();
    test_random_back_to_back();
`ifdef STACK_BOUND_CHECK_EN
    test_bound_fault();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/stack_sequencer.md
# stack_sequencer

Multi-cycle sequencer for the EX/MEM boundary that runs CALL, RET, INT and RTI as sequences of 16-bit stack accesses. It owns the 32-bit stack pointer. While a sequence runs it stalls the front of the pipeline and inserts bubbles into the EX/MEM buffer. When the sequence ends it emits a PC load, plus a flags load for RTI.

## Interface
- SP_RESET, 32'h000F_FFFF: stack pointer value after reset; the stack grows down.
- INT_VECTOR, 32'h0000_0000: PC target loaded at the end of INT.
- SP_LIMIT, 32'h000F_F000: lowest legal push address (used only with STACK_BOUND_CHECK_EN).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  a multi-word stack op is valid in EX this cycle.
- op  in  2  00 CALL, 01 RET, 10 INT, 11 RTI.
- pc_in  in  32  return address to push (CALL/INT).
- target_in  in  32  CALL destination.
- flags_in  in  3  NF|CF|ZF to push (INT).
- mem_ready  in  1  memory accepts the current access this cycle; read data is valid in the same cycle.
- mem_rdata  in  16  read data.
- stall  out  1  freezes PC, IF/ID and ID/EX, and forces a bubble into EX/MEM.
- mem_req  out  1  access request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  32  word address.
- mem_wdata  out  16  write data.
- sp  out  32  current stack pointer.
- pc_load  out  1  one-cycle pulse: load pc_out into PC.
- pc_out  out  32  new PC.
- flags_load  out  1  one-cycle pulse: load flags_out into the flag register.
- flags_out  out  3  NF|CF|ZF.
- done  out  1  one-cycle pulse when a sequence ends.
- stack_fault  out  1  one-cycle pulse when the bound check aborts an op.

## Operation
- States are IDLE, XFER and FIN. A 2-bit word index k and a word count N (2 or 3) are registered at start.
- Push: write mem[sp] = word, then sp <= sp-1.
- Pop: read mem[sp+1], then sp <= sp+1.
- sp arithmetic is modulo 2^32.
- CALL: push pc_in[31:16], then pc_in[15:0]. pc_out = target_in.
- RET: pop the low word, then the high word. pc_out = {high, low}.
- INT: push pc_in[31:16], then pc_in[15:0], then {13'b0, flags_in}. pc_out = INT_VECTOR.
- RTI: pop flags (flags_out = rdata[2:0]), then the PC low word, then the PC high word. pc_out = {high, low}.
- pc_in, target_in, flags_in and op are latched at start, so later changes to these inputs have no effect.
- Transitions:
  - IDLE -> XFER on start.
  - XFER: k advances on each mem_req && mem_ready. XFER -> FIN when word N-1 is accepted.
  - FIN -> IDLE unconditionally.
- Outputs by state:
  - FIN: pc_load=1 and done=1. flags_load=1 only for RTI.
  - XFER: mem_req=1, with mem_we=1 for CALL/INT.
- stall = start || (state != IDLE). It is combinational from start.
- Boundary conditions:
  - start while not IDLE is ignored.
  - If mem_ready is low, mem_addr, mem_wdata, mem_we and sp hold stable.
  - rst mid-sequence returns to IDLE and sets sp = SP_RESET. Words already written are not undone, and no pc_load is issued.
- Reset values: sp = SP_RESET; pc_out = 0, flags_out = 0, mem_addr = 0, mem_wdata = 0; every 1-bit output = 0.
- When not in XFER, mem_addr and mem_wdata are 0.

## Timing
- Start is sampled in cycle 0 and the first access is requested in cycle 1.
- With mem_ready held at 1:
  - accesses occupy cycles 1..N;
  - FIN is cycle N+1;
  - stall is high for cycles 0..N+1 (N+2 cycles in total).
- Each cycle of mem_ready=0 adds one cycle.
- sp updates on the clock edge at which an access is accepted.
- A new start is accepted in the cycle after FIN.

## Configuration
- STACK_BOUND_CHECK_EN defined:
  - At start, the block checks whether a push would write below SP_LIMIT or a pop would read above SP_RESET.
  - If so, it stays in IDLE, pulses stack_fault and stall for that cycle, makes no memory access, leaves sp unchanged, and issues no pc_load or done.
- STACK_BOUND_CHECK_EN undefined: stack_fault is tied to 0 and no check is made. Wrap is modulo 2^32.

## Test plan
- CALL, pc_in=32'h0001_0024, target_in=32'h0000_0100, mem_ready=1 -> expect:
  - write 16'h0001 @000FFFFF, then 16'h0024 @000FFFFE;
  - sp = 000FFFFD;
  - pc_load with pc_out = 32'h100 in cycle 3;
  - stall high for cycles 0..3.
- RET following the CALL, memory model returning the stored words -> expect:
  - reads @000FFFFE and @000FFFFF;
  - pc_out = 32'h0001_0024;
  - sp = 000FFFFF;
  - flags_load stays 0.
- INT, flags_in=3'b101, then RTI -> expect:
  - INT writes 16'h0005 @000FFFFD, sp = 000FFFFC, pc_out = INT_VECTOR;
  - RTI returns flags_out = 101 with flags_load, restores the PC, sp = 000FFFFF.
- CALL with mem_ready low for 3 cycles on the second word -> expect:
  - mem_addr = 000FFFFE and mem_wdata stable through the wait;
  - FIN in cycle 6;
  - stall high for 7 cycles.
- rst asserted in cycle 2 of an INT -> expect:
  - next cycle IDLE, sp = SP_RESET, all outputs 0;
  - no pc_load;
  - a fresh CALL then completes normally.
- With STACK_BOUND_CHECK_EN defined, RET issued at reset sp -> expect:
  - stack_fault pulse;
  - no mem_req;
  - sp unchanged.
